// File: rtl/demux1to3_8b_buf.sv
// demux1to3_8b_buf: valid/ready 1-to-3 word distributor with a one-entry holding register per channel
module demux1to3_8b_buf #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic             bad_sel
`ifdef DEMUX_DROP_CNT_EN
  , output logic [CNT_W-1:0] drop_cnt
`endif
);
  logic [2:0] hit, acc, rdy, vq;
  logic [WIDTH-1:0] dq [3];
  logic drop;
  assign rdy = {out2_ready, out1_ready, out0_ready};
  assign hit = {in_sel == 2'd2, in_sel == 2'd1, in_sel == 2'd0};
  assign in_ready = (&in_sel) | (|(hit & (~vq | rdy)));
  assign acc = hit & {3{in_valid & in_ready}};
  assign drop = in_valid & (&in_sel);
  always_ff @(posedge clk) begin
    if (rst) begin
      vq <= '0;
      bad_sel <= 1'b0;
      for (int k = 0; k < 3; k++) dq[k] <= '0;
    end else begin
      vq <= acc | (vq & ~rdy);
      bad_sel <= drop;
      for (int k = 0; k < 3; k++) dq[k] <= acc[k] ? in_data : dq[k];
    end
  end
  assign {out2_valid, out1_valid, out0_valid} = vq;
  assign out0_data = dq[0];
  assign out1_data = dq[1];
  assign out2_data = dq[2];
`ifdef DEMUX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_demux1to3_8b_buf.sv
// tb_demux1to3_8b_buf: directed and random stimulus against a per-channel one-slot buffer model
module tb_demux1to3_8b_buf;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] out0_data, out1_data, out2_data;
  logic out0_valid, out1_valid, out2_valid;
  logic out0_ready = 1'b0, out1_ready = 1'b0, out2_ready = 1'b0;
  logic bad_sel;
`ifdef DEMUX_DROP_CNT_EN
  logic [CW-1:0] drop_cnt;
  int mdrop;
`endif
  int total = 0, bad = 0;
  logic mfull [4];
  logic [7:0] mdata [4];
  logic mbad;
  logic rdy_seen;

  always #5 clk = ~clk;

  demux1to3_8b_buf #(.WIDTH(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .bad_sel(bad_sel)
`ifdef DEMUX_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [1:0] s, input logic [7:0] d, input logic [2:0] ordy);
    logic exp_rdy;
    logic [2:0] av;
    logic [7:0] ad [3];
    @(negedge clk);
    rst = r; in_valid = v; in_sel = s; in_data = d;
    {out2_ready, out1_ready, out0_ready} = ordy;
    #1;
    exp_rdy = (s == 2'd3) || !mfull[s] || ordy[s];
    rdy_seen = in_ready;
    if (!r) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < 4; k++) begin mfull[k] = 1'b0; mdata[k] = 8'h00; end
      mbad = 1'b0;
`ifdef DEMUX_DROP_CNT_EN
      mdrop = 0;
`endif
    end else begin
      for (int k = 0; k < 3; k++) if (mfull[k] && ordy[k]) mfull[k] = 1'b0;
      if (v && exp_rdy && s != 2'd3) begin mfull[s] = 1'b1; mdata[s] = d; end
      mbad = v && s == 2'd3;
`ifdef DEMUX_DROP_CNT_EN
      if (mbad && mdrop < (1 << CW) - 1) mdrop++;
`endif
    end
    av = {out2_valid, out1_valid, out0_valid};
    ad = '{out0_data, out1_data, out2_data};
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out%0d_valid", k), {31'd0, av[k]}, {31'd0, mfull[k]});
      chk($sformatf("out%0d_data", k), {24'd0, ad[k]}, {24'd0, mdata[k]});
    end
    chk("bad_sel", {31'd0, bad_sel}, {31'd0, mbad});
`ifdef DEMUX_DROP_CNT_EN
    chk("drop_cnt", {{(32-CW){1'b0}}, drop_cnt}, mdrop);
`endif
  endtask

  initial begin
    logic hold, v;
    logic [1:0] s;
    logic [7:0] d;
    for (int k = 0; k < 4; k++) begin mfull[k] = 1'b0; mdata[k] = 8'h00; end
    mbad = 1'b0;
`ifdef DEMUX_DROP_CNT_EN
    mdrop = 0;
`endif
    cyc(1, 1, 0, 8'h55, 3'b111);
    cyc(1, 1, 0, 8'h55, 3'b111);
    chk("rst_v0", {31'd0, out0_valid}, 0);
    chk("rst_d0", {24'd0, out0_data}, 0);
    chk("rst_bad", {31'd0, bad_sel}, 0);
    cyc(0, 1, 1, 8'hA5, 3'b111);
    chk("steer_v1", {31'd0, out1_valid}, 1);
    chk("steer_d1", {24'd0, out1_data}, 32'hA5);
    chk("steer_v02", {30'd0, out2_valid, out0_valid}, 0);
    cyc(0, 0, 0, 8'h00, 3'b111);
    cyc(0, 1, 2, 8'h3C, 3'b011);
    cyc(0, 1, 2, 8'h7E, 3'b011);
    chk("bp_rdy", {31'd0, rdy_seen}, 0);
    chk("bp_hold", {24'd0, out2_data}, 32'h3C);
    cyc(0, 1, 2, 8'h7E, 3'b111);
    chk("bp_rdy_up", {31'd0, rdy_seen}, 1);
    chk("bp_new", {24'd0, out2_data}, 32'h7E);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 0, 8'(i), 3'b111);
      chk("stream_rdy", {31'd0, rdy_seen}, 1);
      chk("stream_d0", {24'd0, out0_data}, i);
    end
    cyc(0, 0, 0, 8'h00, 3'b111);
    cyc(0, 1, 0, 8'h11, 3'b110);
    cyc(0, 1, 0, 8'h22, 3'b110);
    chk("hol_rdy", {31'd0, rdy_seen}, 0);
    chk("hol_d0", {24'd0, out0_data}, 32'h11);
    cyc(0, 1, 1, 8'h33, 3'b110);
    chk("hol_other", {31'd0, rdy_seen}, 1);
    chk("hol_d1", {24'd0, out1_data}, 32'h33);
    cyc(0, 1, 3, 8'hFF, 3'b110);
    chk("inv_rdy", {31'd0, rdy_seen}, 1);
    chk("inv_bad", {31'd0, bad_sel}, 1);
    chk("inv_v0", {31'd0, out0_valid}, 1);
    cyc(0, 0, 3, 8'hFF, 3'b110);
    chk("inv_bad_once", {31'd0, bad_sel}, 0);
`ifdef DEMUX_DROP_CNT_EN
    for (int i = 0; i < 4; i++) cyc(0, 1, 3, 8'hFF, 3'b111);
    chk("drop_sat", {{(32-CW){1'b0}}, drop_cnt}, 3);
`endif
    hold = 1'b0; v = 1'b0; s = '0; d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = 8'($urandom);
      end
      if ($urandom_range(0, 99) == 0) begin
        cyc(1, v, s, d, 3'($urandom));
        hold = 1'b0;
      end else begin
        cyc(0, v, s, d, 3'($urandom));
        hold = v && !rdy_seen;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
